bsg_axil_store_packer_pipelined: RTL and testbench
==================================================

// Module: bsg_axil_store_packer_pipelined
// PURPOSE
//  AXI4-Lite subordinate that packs AXI-Lite reads and writes into single-word command packets of the form
//  {write_not_read, addr[payload_addr_width_p-1:0], data[payload_data_width_p-1:0]}, for a serial/host link.
//  Supports up to els_p outstanding transactions, answered in issue order, with fair read/write arbitration.
//  Bad-address and partial-strobe requests get SLVERR and issue no packet. Sits between an AXI-Lite
//  crossbar port and a narrow command/response link.
// PARAMETERS
//  axil_addr_width_p     (none)  AXI-Lite address width
//  axil_data_width_p     (none)  AXI-Lite data width; also packet width
//  payload_data_width_p  (none)  data bits per packet, multiple of 8, <= axil_data_width_p
//  payload_addr_width_p  axil_data_width_p-payload_data_width_p-1  address bits per packet
//  addr_shift_p          0       AXI address right-shift (byte->word) before packing
//  els_p                 4       max outstanding transactions (>=1)
// PORTS
//  clk_i        in   1     clock
//  reset_n_i    in   1     reset, synchronous, active-low
//  s_axil_aw{addr,prot,valid,ready}, s_axil_w{data,strb,valid,ready}, s_axil_b{resp,valid,ready},
//  s_axil_ar{addr,prot,valid,ready}, s_axil_r{data,resp,valid,ready}: standard AXI4-Lite subordinate, axil widths
//  data_o       out  axil_data_width_p  command packet, zero-extended at MSB if narrower
//  v_o          out  1     packet valid
//  ready_i      in   1     link accepts packet
//  data_i       in   axil_data_width_p  read response data from link
//  v_i          in   1     response valid
//  ready_o      out  1     response consumed
// BEHAVIOUR
//  Reset (reset_n_i==0 at posedge): tracker empty, rr priority = read; all valid/ready outputs 0 while in reset.
//  Address: a = axaddr >> addr_shift_p; addr error if any bit of a above payload_addr_width_p is 1.
//  Strobe: write error if any wstrb bit covering payload bytes [payload_data_width_p/8-1:0] is 0.
//  Write candidate = awvalid & wvalid (never accept aw or w alone). Read candidate = arvalid.
//  Arbitration: if both are candidates, grant the one not granted last; otherwise grant the sole candidate.
//  Issue (0-cycle, combinational): granted, tracker not full, and (err | ready_i).
//    v_o = granted & ~err & ~full. awready=wready (or arready) = issue. err requests never raise v_o.
//    Read packet data field = 0. Write packet data field = wdata[payload_data_width_p-1:0].
//  Tracker: FIFO of {is_write, err}, enqueue on issue. full => no awready/wready/arready.
//  Head is write: bvalid=1, bresp=err?SLVERR:OKAY; dequeue on bready.
//  Head is read, err: rvalid=1, rdata=0, rresp=SLVERR, ready_o=0; dequeue on rready.
//  Head is read, ok: rvalid=v_i, rdata=data_i, rresp=OKAY, ready_o=rready; dequeue on v_i&rready.
//  v_i while head is empty or a write: protocol violation; ready_o=0 and data held (assert in sim).
//  Enqueue and dequeue may occur in the same cycle, including when full (dequeue first; full only blocks
//  if not dequeuing — FIFO without bypass is acceptable; state which in RTL).
//  Issued-but-unanswered reads are lost on reset; the link must be reset together with this block.
//  No combinational path from bready/rready to aw/w/arready.
// STRUCTURE
//  bsg_axi_pkg: reuse axi_resp_type_e; add packed struct bsg_axil_store_pkt_s macro (wnr, addr, data).
//  Sub-module: tracker = bsg_fifo_1r1w_small (width 2, els_p); arbiter is inline 1-bit rr flag.
// TESTING (axil 32b, payload data 8b, payload addr 23b, shift 0, els_p 4)
//  1 write aw=0x10,w=0xAB,strb=0x1,ready_i=1 -> data_o=0x800010AB same cycle; bvalid next cycle, OKAY
//  2 read ar=0x20, ready_i=1, then v_i data_i=0x5A -> data_o=0x00002000; rdata=0x5A, OKAY
//  3 four reads back-to-back, ready_i=1, rready=0 -> 4 issues, 5th arready=0 until first rready
//  4 aw&w and ar valid every cycle, ready_i=1 -> issues alternate W,R,W,R; responses in issue order
//  5 aw=0x0080_0000 (bit 23 set) -> v_o=0, bresp=SLVERR; strb=0x2 at 0x4 -> bresp=SLVERR
//  6 reset_n_i=0 with 2 reads outstanding -> all valids 0 same cycle; after release, tracker empty

Source files
------------

// File: rtl/bsg_axil_store_packer_pipelined_pkg.sv
// Shared types for the AXI-Lite store packer: response codes and the
// per-transaction tracker entry kept while a response is pending.
package bsg_axil_store_packer_pipelined_pkg;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_type_e;

    typedef struct packed {
        logic is_write;
        logic err;
    } tracker_entry_s;

    localparam int tracker_width_lp = $bits(tracker_entry_s);

    function automatic axi_resp_type_e resp_for(input logic err);
        return err ? e_axi_resp_slverr : e_axi_resp_okay;
    endfunction

endpackage

// File: rtl/bsg_axil_store_packer_pipelined_tracker.sv
// Small in-order FIFO of outstanding transactions. No bypass: an entry
// written this cycle is visible at the head only from the next cycle.
module bsg_axil_store_packer_pipelined_tracker
    import bsg_axil_store_packer_pipelined_pkg::*;
    #(parameter int els_p = 4)
    (input  logic           clk_i,
     input  logic           reset_n_i,
     input  logic           v_i,
     input  tracker_entry_s data_i,
     output logic           ready_o,
     output logic           v_o,
     output tracker_entry_s data_o,
     input  logic           yumi_i);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    tracker_entry_s        mem_q [els_p];
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (v_i)
            wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + 1'b1;
        if (yumi_i)
            rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + 1'b1;
        if (v_i & ~yumi_i)
            count_d = count_q + 1'b1;
        else if (~v_i & yumi_i)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i)
            mem_q[wptr_q] <= data_i;
    end

    assign ready_o = (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/bsg_axil_store_packer_pipelined.sv
// AXI-Lite subordinate that turns reads/writes into single-word command packets
// {wnr, addr, data} and returns responses in issue order from a small tracker.
module bsg_axil_store_packer_pipelined
    import bsg_axil_store_packer_pipelined_pkg::*;
    #(parameter int axil_addr_width_p    = 32,
      parameter int axil_data_width_p    = 32,
      parameter int payload_data_width_p = 8,
      parameter int payload_addr_width_p = axil_data_width_p - payload_data_width_p - 1,
      parameter int addr_shift_p         = 0,
      parameter int els_p                = 4)
    (input  logic                           clk_i,
     input  logic                           reset_n_i,
     input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
     input  logic [2:0]                     s_axil_awprot_i,
     input  logic                           s_axil_awvalid_i,
     output logic                           s_axil_awready_o,
     input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
     input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
     input  logic                           s_axil_wvalid_i,
     output logic                           s_axil_wready_o,
     output logic [1:0]                     s_axil_bresp_o,
     output logic                           s_axil_bvalid_o,
     input  logic                           s_axil_bready_i,
     input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
     input  logic [2:0]                     s_axil_arprot_i,
     input  logic                           s_axil_arvalid_i,
     output logic                           s_axil_arready_o,
     output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
     output logic [1:0]                     s_axil_rresp_o,
     output logic                           s_axil_rvalid_o,
     input  logic                           s_axil_rready_i,
     output logic [axil_data_width_p-1:0]   data_o,
     output logic                           v_o,
     input  logic                           ready_i,
     input  logic [axil_data_width_p-1:0]   data_i,
     input  logic                           v_i,
     output logic                           ready_o);

    localparam int pa_lp       = payload_addr_width_p;
    localparam int pd_lp       = payload_data_width_p;
    localparam int pkt_w_lp    = 1 + pa_lp + pd_lp;
    localparam int strb_lp     = pd_lp / 8;
    localparam int addr_ext_lp = (pa_lp > axil_addr_width_p) ? pa_lp : axil_addr_width_p;

    logic [addr_ext_lp-1:0] aw_word, ar_word;
    logic                   w_err, r_err, sel_err;
    logic                   w_cand, r_cand, grant_w, grant_r, granted, issue;
    logic                   prio_write_q, prio_write_d;
    logic [pkt_w_lp-1:0]    pkt;
    logic                   trk_ready, trk_v, trk_deq, head_ok_read;
    tracker_entry_s         head, enq_entry;
    logic                   unused_ok;

    assign aw_word = addr_ext_lp'(s_axil_awaddr_i) >> addr_shift_p;
    assign ar_word = addr_ext_lp'(s_axil_araddr_i) >> addr_shift_p;
    assign w_err   = (|(aw_word >> pa_lp)) | ~(&s_axil_wstrb_i[strb_lp-1:0]);
    assign r_err   = |(ar_word >> pa_lp);

    // Round-robin: prio_write_q set means the write side wins the next tie.
    assign w_cand  = s_axil_awvalid_i & s_axil_wvalid_i;
    assign r_cand  = s_axil_arvalid_i;
    assign grant_w = w_cand & (~r_cand | prio_write_q);
    assign grant_r = r_cand & ~grant_w;
    assign granted = grant_w | grant_r;
    assign sel_err = grant_w ? w_err : r_err;

    // Errored requests retire without the link, so they need no ready_i.
    assign issue   = reset_n_i & granted & trk_ready & (sel_err | ready_i);
    assign v_o     = reset_n_i & granted & ~sel_err & trk_ready;

    assign s_axil_awready_o = issue & grant_w;
    assign s_axil_wready_o  = issue & grant_w;
    assign s_axil_arready_o = issue & grant_r;

    assign pkt    = grant_w ? {1'b1, aw_word[pa_lp-1:0], s_axil_wdata_i[pd_lp-1:0]}
                            : {1'b0, ar_word[pa_lp-1:0], {pd_lp{1'b0}}};
    assign data_o = axil_data_width_p'(pkt);

    assign prio_write_d = issue ? grant_r : prio_write_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            prio_write_q <= 1'b0;
        else
            prio_write_q <= prio_write_d;
    end

    assign enq_entry = '{is_write: grant_w, err: sel_err};

    bsg_axil_store_packer_pipelined_tracker #(.els_p(els_p)) tracker (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (issue),
        .data_i   (enq_entry),
        .ready_o  (trk_ready),
        .v_o      (trk_v),
        .data_o   (head),
        .yumi_i   (trk_deq)
    );

    assign head_ok_read    = trk_v & ~head.is_write & ~head.err;
    assign s_axil_bvalid_o = reset_n_i & trk_v & head.is_write;
    assign s_axil_bresp_o  = resp_for(head.err);
    assign s_axil_rvalid_o = reset_n_i & trk_v & ~head.is_write & (head.err | v_i);
    assign s_axil_rresp_o  = resp_for(head.err);
    assign s_axil_rdata_o  = head.err ? '0 : data_i;
    assign ready_o         = reset_n_i & head_ok_read & s_axil_rready_i;

    assign trk_deq = (s_axil_bvalid_o & s_axil_bready_i) | (s_axil_rvalid_o & s_axil_rready_i);

    assign unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_wdata_i, s_axil_wstrb_i,
                         aw_word, ar_word};

    // Link responses are only legal while an accepted read is waiting for them.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                     v_i |-> (trk_v && !head.is_write));

endmodule

// File: tb/tb_bsg_axil_store_packer_pipelined.sv
// Bench for the AXI-Lite store packer: directed vector table, multi-cycle
// corner sequences, then random traffic against a transaction-level model.
module tb_bsg_axil_store_packer_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] awaddr, wdata, araddr, rdata, data_o, data_i;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic        v_o, ready_i, v_i, ready_o;

    always #5 clk = ~clk;

    bsg_axil_store_packer_pipelined #(
        .axil_addr_width_p(32), .axil_data_width_p(32), .payload_data_width_p(8),
        .payload_addr_width_p(23), .addr_shift_p(0), .els_p(4)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
        .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
        .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
        .data_i(data_i), .v_i(v_i), .ready_o(ready_o)
    );

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLV  = 2'b10;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        ready_i = 0; v_i = 0; awprot = 0; arprot = 0;
        awaddr = 0; wdata = 0; wstrb = 4'hF; araddr = 0; data_i = 0;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_v_o"}, v_o, 0);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_ready_o"}, ready_o, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_w;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        bit          rdy;
        logic [31:0] link;
        bit          e_v;
        logic [31:0] e_pkt;
        bit          e_acc;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(bit is_w, logic [31:0] addr, logic [31:0] wd, logic [3:0] strb,
                                bit rdy, logic [31:0] link, bit e_v, logic [31:0] e_pkt,
                                bit e_acc, logic [1:0] e_resp, logic [31:0] e_rdata);
        vec_t v;
        v.is_w = is_w; v.addr = addr; v.wd = wd; v.strb = strb; v.rdy = rdy; v.link = link;
        v.e_v = e_v; v.e_pkt = e_pkt; v.e_acc = e_acc; v.e_resp = e_resp; v.e_rdata = e_rdata;
        return v;
    endfunction

    vec_t vt[10];

    // ---------------- transaction-level reference model ----------------
    typedef struct packed { bit w; bit e; } ent_t;
    ent_t mq[$];
    bit   m_last_read;
    bit   m_iss, m_iss_w;

    task automatic model_cycle(input bit vi_always);
        bit wc, rc, gw, gr, werr, rerr, err, full, iss, ev, e_b, e_r, e_ro, deq, okread;
        logic [31:0] epkt;
        okread = (mq.size() > 0) && !mq[0].w && !mq[0].e;
        v_i    = okread ? (vi_always ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        data_i = $urandom;
        wc   = awvalid && wvalid;
        rc   = arvalid;
        gw   = wc && (!rc || m_last_read);
        gr   = rc && !gw;
        werr = ((awaddr >> 23) != 0) || !wstrb[0];
        rerr = (araddr >> 23) != 0;
        err  = gw ? werr : rerr;
        full = mq.size() >= 4;
        iss  = (gw || gr) && !full && (err || ready_i);
        ev   = (gw || gr) && !err && !full;
        epkt = gw ? (32'h8000_0000 | ((awaddr & 32'h7F_FFFF) << 8) | (wdata & 32'hFF))
                  : ((araddr & 32'h7F_FFFF) << 8);
        e_b  = (mq.size() > 0) && mq[0].w;
        e_r  = (mq.size() > 0) && !mq[0].w && (mq[0].e || v_i);
        e_ro = okread && rready;
        #2;
        chk("m_awready", awready, iss && gw);
        chk("m_wready", wready, iss && gw);
        chk("m_arready", arready, iss && gr);
        chk("m_v_o", v_o, ev);
        if (ev) chk("m_data_o", data_o, epkt);
        chk("m_bvalid", bvalid, e_b);
        chk("m_rvalid", rvalid, e_r);
        chk("m_ready_o", ready_o, e_ro);
        if (e_b) chk("m_bresp", bresp, mq[0].e ? SLV : OKAY);
        if (e_r) begin
            chk("m_rresp", rresp, mq[0].e ? SLV : OKAY);
            chk("m_rdata", rdata, mq[0].e ? 32'h0 : data_i);
        end
        deq   = (e_b && bready) || (e_r && rready);
        m_iss = iss;
        m_iss_w = gw;
        edge_();
        if (deq) void'(mq.pop_front());
        if (iss) begin
            mq.push_back('{w: gw, e: err});
            m_last_read = gr;
        end
    endtask

    initial begin
        bit have_prev, prev_w;

        vt[0] = mk(1, 32'h10,        32'hAB,        4'h1, 1, 0,            1, 32'h8000_10AB, 1, OKAY, 0);
        vt[1] = mk(0, 32'h20,        0,             4'h0, 1, 32'h5A,       1, 32'h0000_2000, 1, OKAY, 32'h5A);
        vt[2] = mk(1, 32'h0080_0000, 32'hCD,        4'h1, 1, 0,            0, 0,             1, SLV,  0);
        vt[3] = mk(1, 32'h4,         32'hEF,        4'h2, 1, 0,            0, 0,             1, SLV,  0);
        vt[4] = mk(0, 32'h0080_0000, 0,             4'h0, 1, 0,            0, 0,             1, SLV,  0);
        vt[5] = mk(1, 32'h7F_FFFF,   32'h1234_5678, 4'hF, 1, 0,            1, 32'hFFFF_FF78, 1, OKAY, 0);
        vt[6] = mk(0, 32'h7F_FFFF,   0,             4'h0, 1, 32'hDEADBEEF, 1, 32'h7FFF_FF00, 1, OKAY, 32'hDEADBEEF);
        vt[7] = mk(1, 32'h30,        32'h99,        4'hF, 0, 0,            1, 32'h8000_3099, 0, OKAY, 0);
        vt[8] = mk(1, 32'h8000_0000, 32'h11,        4'hF, 0, 0,            0, 0,             1, SLV,  0);
        vt[9] = mk(1, 32'h8,         32'h22,        4'hE, 1, 0,            0, 0,             1, SLV,  0);

        // ---------------- reset: everything quiet even with inputs asserted ----------------
        idle();
        reset_n = 0;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1; ready_i = 1; v_i = 1;
        edge_();
        #2;
        chk_all_quiet("reset");
        edge_();
        idle();
        reset_n = 1;
        edge_();

        // ---------------- table ----------------
        for (int i = 0; i < 10; i++) begin
            idle();
            if (vt[i].is_w) begin
                awvalid = 1; wvalid = 1; awaddr = vt[i].addr; wdata = vt[i].wd; wstrb = vt[i].strb;
            end else begin
                arvalid = 1; araddr = vt[i].addr;
            end
            ready_i = vt[i].rdy;
            #2;
            chk($sformatf("vec%0d_v_o", i), v_o, vt[i].e_v);
            if (vt[i].e_v) chk($sformatf("vec%0d_data_o", i), data_o, vt[i].e_pkt);
            chk($sformatf("vec%0d_accept", i), vt[i].is_w ? (awready & wready) : arready, vt[i].e_acc);
            edge_();
            idle();
            #2;
            if (!vt[i].e_acc) begin
                chk($sformatf("vec%0d_no_b", i), bvalid, 0);
                chk($sformatf("vec%0d_no_r", i), rvalid, 0);
            end else if (vt[i].is_w) begin
                chk($sformatf("vec%0d_bvalid", i), bvalid, 1);
                chk($sformatf("vec%0d_bresp", i), bresp, vt[i].e_resp);
                bready = 1;
            end else if (vt[i].e_resp == SLV) begin
                chk($sformatf("vec%0d_rvalid", i), rvalid, 1);
                chk($sformatf("vec%0d_rresp", i), rresp, SLV);
                chk($sformatf("vec%0d_rdata", i), rdata, 0);
                chk($sformatf("vec%0d_ready_o", i), ready_o, 0);
                rready = 1;
            end else begin
                chk($sformatf("vec%0d_rvalid_wait", i), rvalid, 0);
                v_i = 1; data_i = vt[i].link; rready = 1;
                #1;
                chk($sformatf("vec%0d_rvalid", i), rvalid, 1);
                chk($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
                chk($sformatf("vec%0d_rresp", i), rresp, OKAY);
                chk($sformatf("vec%0d_ready_o", i), ready_o, 1);
            end
            edge_();
            idle();
        end

        // ---------------- four outstanding reads fill the tracker ----------------
        idle();
        arvalid = 1; araddr = 32'h40; ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("fill%0d_arready", i), arready, 1);
            chk($sformatf("fill%0d_v_o", i), v_o, 1);
            edge_();
        end
        #2;
        chk("full_arready", arready, 0);
        chk("full_v_o", v_o, 0);
        edge_();
        #2;
        chk("full_arready_hold", arready, 0);
        v_i = 1; data_i = 32'h33; rready = 1;
        #1;
        chk("full_rvalid", rvalid, 1);
        chk("full_rdata", rdata, 32'h33);
        chk("full_no_bypass", arready, 0);
        edge_();
        #2;
        chk("after_deq_arready", arready, 1);
        edge_();
        arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("drain%0d_rvalid", i), rvalid, 1);
            edge_();
        end
        idle();

        // ---------------- reset with reads outstanding ----------------
        arvalid = 1; araddr = 32'h44; ready_i = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk($sformatf("pre_rst%0d_arready", i), arready, 1);
            edge_();
        end
        reset_n = 0;
        awvalid = 1; wvalid = 1; bready = 1; rready = 1; v_i = 1;
        #2;
        chk_all_quiet("mid_rst");
        edge_();
        reset_n = 1;
        v_i = 0; bready = 0; rready = 0; ready_i = 0;
        awaddr = 32'h50; wdata = 32'h44; wstrb = 4'hF; araddr = 32'h60;
        #2;
        chk("post_rst_prio_v_o", v_o, 1);
        chk("post_rst_prio_pkt", data_o, 32'h0000_6000);
        chk("post_rst_arready_stall", arready, 0);
        edge_();
        arvalid = 0; ready_i = 1;
        #2;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wpkt", data_o, 32'h8000_5044);
        edge_();
        idle();
        #2;
        chk("post_rst_bvalid", bvalid, 1);
        chk("post_rst_bresp", bresp, OKAY);
        chk("post_rst_rvalid", rvalid, 0);
        bready = 1;
        edge_();
        idle();

        // Tracker is empty and the last grant was a write, so reads win the next tie.
        mq.delete();
        m_last_read = 0;

        // ---------------- both sides always requesting: strict alternation ----------------
        have_prev = 0;
        prev_w    = 0;
        for (int i = 0; i < 10; i++) begin
            awvalid = 1; wvalid = 1; arvalid = 1;
            awaddr = 32'h100 + i; wdata = 32'h5 + i; wstrb = 4'hF; araddr = 32'h200 + i;
            ready_i = 1; bready = 1; rready = 1;
            model_cycle(1);
            if (m_iss) begin
                if (have_prev) chk($sformatf("alt%0d", i), m_iss_w, !prev_w);
                else           chk("alt_first_read", m_iss_w, 0);
                have_prev = 1;
                prev_w    = m_iss_w;
            end
        end
        idle();

        // ---------------- random traffic ----------------
        for (int i = 0; i < 400; i++) begin
            awvalid = 1'($urandom_range(0, 1));
            wvalid  = 1'($urandom_range(0, 1));
            arvalid = 1'($urandom_range(0, 1));
            awaddr  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h7F_FFFC);
            araddr  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h7F_FFFC);
            wdata   = $urandom;
            wstrb   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
            awprot  = 3'($urandom);
            arprot  = 3'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            bready  = 1'($urandom_range(0, 1));
            rready  = 1'($urandom_range(0, 1));
            model_cycle(0);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
